// File: rtl/sub64_pipe.sv
// Pipelined a - b - bin, one CHUNK-bit slice per stage plus an output register; latency STAGES cycles.
// Whole pipe advances only when the output register is empty or being drained.
module sub64_pipe #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);
  localparam int STAGES = WIDTH / CHUNK;

  logic             en;
  logic             vld [STAGES];
  logic [WIDTH-1:0] sa  [STAGES];
  logic [WIDTH-1:0] sb  [STAGES];
  logic [WIDTH-1:0] sd  [STAGES];
  logic             sbr [STAGES];
  logic [CHUNK:0]   res [STAGES];

  assign en       = !out_valid || out_ready;
  assign in_ready = en && !rst;

  // Top bit of each CHUNK+1 wide result is the borrow out of that slice.
  always_comb begin
    res[0] = {1'b0, a[CHUNK-1:0]} - {1'b0, b[CHUNK-1:0]} - {{CHUNK{1'b0}}, bin};
    for (int k = 1; k < STAGES; k++) begin
      res[k] = {1'b0, sa[k-1][k*CHUNK +: CHUNK]} - {1'b0, sb[k-1][k*CHUNK +: CHUNK]}
             - {{CHUNK{1'b0}}, sbr[k-1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        vld[k] <= 1'b0;
        sa[k]  <= '0;
        sb[k]  <= '0;
        sd[k]  <= '0;
        sbr[k] <= 1'b0;
      end
      out_valid <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
    end else if (en) begin
      vld[0] <= in_valid;
      if (in_valid) begin
        sa[0]            <= a;
        sb[0]            <= b;
        sd[0]            <= '0;
        sd[0][CHUNK-1:0] <= res[0][CHUNK-1:0];
        sbr[0]           <= res[0][CHUNK];
      end
      // Data registers only load behind a valid beat, so bubbles never disturb held results.
      for (int k = 1; k < STAGES; k++) begin
        vld[k] <= vld[k-1];
        if (vld[k-1]) begin
          sa[k]                    <= sa[k-1];
          sb[k]                    <= sb[k-1];
          sd[k]                    <= sd[k-1];
          sd[k][k*CHUNK +: CHUNK]  <= res[k][CHUNK-1:0];
          sbr[k]                   <= res[k][CHUNK];
        end
      end
      out_valid <= vld[STAGES-1];
      if (vld[STAGES-1]) begin
        diff <= sd[STAGES-1];
        bout <= sbr[STAGES-1];
        zero <= (sd[STAGES-1] == '0);
        ovf  <= (sa[STAGES-1][WIDTH-1] != sb[STAGES-1][WIDTH-1]) &&
                (sd[STAGES-1][WIDTH-1] != sa[STAGES-1][WIDTH-1]);
      end
    end
  end
endmodule

// File: tb/tb_sub64_pipe.sv
// Directed bench for sub64_pipe: single beats, streaming with backpressure, reset mid-flight.
module tb_sub64_pipe;
  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] diff;
  logic        bout;
  logic        zero;
  logic        ovf;

  int total = 0;
  int bad   = 0;

  logic [63:0] got [8];
  int          n_got;
  int          stall_cyc;
  int          stall_bad;

  sub64_pipe #(.WIDTH(64), .CHUNK(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .zero(zero), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sends one beat and counts edges until out_valid rises (bounded at 20).
  task automatic send_single(input logic [63:0] av, input logic [63:0] bv, input logic bi,
                             output int lat);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = av; b = bv; bin = bi;
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    in_valid = 1'b0;
    a = '1; b = '1; bin = 1'b1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  // Streams av/bv with out_ready low for cycles slo..shi; collects results into got[].
  task automatic stream(input logic [63:0] av [6], input logic [63:0] bv [6],
                        input int slo, input int shi);
    int          sent;
    logic [63:0] prev;
    logic        prev_stall;
    sent = 0; prev = '0; prev_stall = 1'b0;
    n_got = 0; stall_cyc = 0; stall_bad = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      out_ready = !(c >= slo && c <= shi);
      if (sent < 6) begin
        in_valid = 1'b1; a = av[sent]; b = bv[sent]; bin = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && !out_ready) begin
        stall_cyc++;
        if (in_ready !== 1'b0) stall_bad++;
        if (prev_stall && diff !== prev) stall_bad++;
        prev = diff;
        prev_stall = 1'b1;
      end else begin
        prev_stall = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (n_got < 8) got[n_got] = diff;
        n_got++;
      end
      if (in_valid && in_ready) sent++;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '1; b = '0; bin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b want=0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
    total++; if (diff !== 64'h0) begin bad++; $display("FAIL rst_diff got=%h want=0", diff); end
    total++; if ({bout, zero, ovf} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b want=000", {bout, zero, ovf}); end
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_basic;
    int lat;
    send_single(64'd2, 64'd1, 1'b0, lat);
    total++; if (lat !== 4) begin bad++; $display("FAIL basic_latency got=%0d want=4", lat); end
    total++; if (diff !== 64'h1) begin bad++; $display("FAIL basic_diff got=%h want=1", diff); end
    total++; if ({bout, zero, ovf} !== 3'b000) begin bad++; $display("FAIL basic_flags got=%b want=000", {bout, zero, ovf}); end
    send_single(64'd5, 64'd3, 1'b1, lat);
    total++; if (diff !== 64'h1) begin bad++; $display("FAIL basic_bin_diff got=%h want=1", diff); end
  endtask

  task automatic test_underflow;
    int lat;
    send_single(64'd0, 64'd1, 1'b0, lat);
    total++; if (diff !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL uflow_diff got=%h want=ffffffffffffffff", diff); end
    total++; if ({bout, zero, ovf} !== 3'b100) begin bad++; $display("FAIL uflow_flags got=%b want=100", {bout, zero, ovf}); end
    send_single(64'd0, 64'd0, 1'b1, lat);
    total++; if ({bout, diff} !== {1'b1, 64'hFFFF_FFFF_FFFF_FFFF}) begin bad++; $display("FAIL uflow_bin got=%b/%h want=1/ffffffffffffffff", bout, diff); end
  endtask

  task automatic test_cross_chunk;
    int lat;
    send_single(64'h0000_0000_0001_0000, 64'd0, 1'b1, lat);
    total++; if (diff !== 64'h0000_0000_0000_FFFF) begin bad++; $display("FAIL cross_diff got=%h want=ffff", diff); end
    total++; if (bout !== 1'b0) begin bad++; $display("FAIL cross_bout got=%b want=0", bout); end
    send_single(64'h0001_0000_0000_0000, 64'd1, 1'b0, lat);
    total++; if (diff !== 64'h0000_FFFF_FFFF_FFFF) begin bad++; $display("FAIL cross_deep got=%h want=0000ffffffffffff", diff); end
  endtask

  task automatic test_ovf_zero;
    int lat;
    send_single(64'h8000_0000_0000_0000, 64'd1, 1'b0, lat);
    total++; if (diff !== 64'h7FFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL ovf_diff got=%h want=7fffffffffffffff", diff); end
    total++; if ({bout, zero, ovf} !== 3'b001) begin bad++; $display("FAIL ovf_flags got=%b want=001", {bout, zero, ovf}); end
    send_single(64'hAAAA_AAAA_AAAA_AAAA, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, lat);
    total++; if (diff !== 64'h0) begin bad++; $display("FAIL zero_diff got=%h want=0", diff); end
    total++; if ({bout, zero, ovf} !== 3'b010) begin bad++; $display("FAIL zero_flags got=%b want=010", {bout, zero, ovf}); end
  endtask

  task automatic test_backpressure;
    logic [63:0] av [6];
    logic [63:0] bv [6];
    for (int i = 0; i < 6; i++) begin av[i] = 64'(i + 10); bv[i] = 64'(i); end
    stream(av, bv, 5, 7);
    total++; if (stall_cyc !== 3) begin bad++; $display("FAIL bp_stall_cycles got=%0d want=3", stall_cyc); end
    total++; if (stall_bad !== 0) begin bad++; $display("FAIL bp_hold got=%0d violations want=0", stall_bad); end
    total++; if (n_got !== 6) begin bad++; $display("FAIL bp_count got=%0d want=6", n_got); end
    for (int i = 0; i < 6 && i < n_got; i++) begin
      total++; if (got[i] !== 64'd10) begin bad++; $display("FAIL bp_result[%0d] got=%h want=a", i, got[i]); end
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] av [6];
    logic [63:0] bv [6];
    for (int i = 0; i < 6; i++) begin av[i] = 64'(i * 100 + 50); bv[i] = 64'(i); end
    stream(av, bv, 100, 100);
    total++; if (n_got !== 6) begin bad++; $display("FAIL b2b_count got=%0d want=6", n_got); end
    for (int i = 0; i < 6 && i < n_got; i++) begin
      total++; if (got[i] !== 64'(i * 99 + 50)) begin bad++; $display("FAIL b2b_order[%0d] got=%0d want=%0d", i, got[i], i * 99 + 50); end
    end
  endtask

  task automatic test_reset_midflight;
    int acc;
    int seen;
    int lat;
    acc = 0; seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      out_ready = 1'b1; in_valid = 1'b1; a = 64'(100 + c); b = 64'(c); bin = 1'b0;
      #1;
      if (in_ready) acc++;
    end
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_in_ready got=%b want=0", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    total++; if ({out_valid, diff, bout, zero, ovf} !== 68'h0) begin bad++; $display("FAIL mid_rst_outputs got=%b/%h want=0/0", out_valid, diff); end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen++;
    end
    total++; if (acc !== 3) begin bad++; $display("FAIL mid_accepted got=%0d want=3", acc); end
    total++; if (seen !== 0) begin bad++; $display("FAIL mid_stale_beats got=%0d want=0", seen); end
    send_single(64'd5, 64'd3, 1'b0, lat);
    total++; if (lat !== 4) begin bad++; $display("FAIL mid_post_latency got=%0d want=4", lat); end
    total++; if (diff !== 64'd2) begin bad++; $display("FAIL mid_post_diff got=%h want=2", diff); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underflow();
    test_cross_chunk();
    test_ovf_zero();
    test_backpressure();
    test_back_to_back();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sub64_pipe.md
Name: sub64_pipe

Overview:
- Pipelined 64-bit subtractor with borrow-in and borrow-out; the inverse datapath of the team's 64-bit carry-lookahead adder (cla64bit).
- Computes diff = a - b - bin in CHUNK-bit slices, one slice per pipeline stage, with the borrow registered between stages.
- Uses a valid/ready handshake on both input and output, so it can sit in a streaming ALU path with backpressure.
- Also produces status flags for compare and branch logic.

Parameters:
- WIDTH, 64, operand width in bits.
- CHUNK, 16, bits resolved per stage. WIDTH must be an integer multiple of CHUNK. STAGES = WIDTH/CHUNK, which is 4 by default.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts the result.
- diff  output  WIDTH  (a - b - bin) mod 2^WIDTH.
- bout  output  1  unsigned borrow-out: 1 iff a < b + bin.
- zero  output  1  diff == 0.
- ovf  output  1  two's-complement signed overflow: a[MSB] != b[MSB] and diff[MSB] != a[MSB].

Behaviour:
- **Reset:** on rst=1 at a clock edge, the following clear to 0:
  - every stage valid bit and every stage data/borrow register;
  - out_valid, diff, bout, zero and ovf.
- **Reset mid-operation:** all in-flight beats are discarded and no partial result ever appears. in_ready is 0 while rst=1.
- **Stall enable:** en = !out_valid || out_ready. in_ready = en && !rst (combinational).
- **Input transfer:** occurs when in_valid && in_ready at a rising edge.
- **Output transfer:** occurs when out_valid && out_ready at a rising edge.
- **Advance:** the pipeline advances only when en=1. When en=0, every stage register holds, including valid bits.
- **Bubbles:** are not collapsed.
- **Stage 0:** on transfer, registers:
  - diff slice [CHUNK-1:0] = a - b - bin over CHUNK bits;
  - the borrow out of that slice;
  - the remaining upper slices of a and b;
  - the MSBs of a and b, for ovf.
- **Stage 0 without a transfer:** if en=1 and no input transfer occurs, stage 0 valid becomes 0.
- **Stage k (1..STAGES-1):** computes slice k from the carried-forward operand slices and the registered borrow of stage k-1. It forwards accumulated diff bits, its borrow and the pending upper slices.
- **Output register:** the last stage drives diff and bout. zero and ovf are derived from the completed diff and registered in the same stage as diff, so all outputs are mutually consistent.
- **Latency and throughput:**
  - out_valid rises exactly STAGES cycles after the input transfer edge when out_ready stays 1.
  - Throughput is 1 beat/cycle.
- **Output stability:** while out_valid=1 and out_ready=0, diff, bout, zero and ovf hold stable and no beat is lost or duplicated.
- **Simultaneous transfers:** an input transfer and an output transfer in the same cycle are legal. The pipeline shifts by one.
- **Ordering:** beats exit in acceptance order.
- **Width rules:**
  - All slice arithmetic is CHUNK+1 bits wide; the extra bit is the borrow.
  - The final borrow is bout. There is no saturation; diff wraps mod 2^WIDTH.
- **Input hold:** inputs are sampled only on a transfer edge, so the source may change a, b or bin freely when not transferring.

Test Plan:
- **Basic subtract:** a=2, b=1, bin=0, out_ready=1 -> after 4 cycles out_valid=1, diff=0x0000000000000001, bout=0, zero=0, ovf=0.
- **Underflow wrap:** a=0, b=1, bin=0 -> diff=0xFFFFFFFFFFFFFFFF, bout=1, zero=0, ovf=0.
- **Cross-chunk borrow:** a=0x0000000000010000, b=0, bin=1 -> diff=0x000000000000FFFF, bout=0. This checks borrow propagation across the stage-0/stage-1 boundary.
- **Signed overflow and zero:**
  - a=0x8000000000000000, b=1, bin=0 -> diff=0x7FFFFFFFFFFFFFFF, ovf=1, bout=0.
  - a=b=0xAAAAAAAAAAAAAAAA, bin=0 -> diff=0, zero=1, bout=0.
- **Backpressure:**
  - Stream 6 back-to-back beats (a=i+10, b=i, i=0..5) with out_ready=0 for cycles 5-7.
  - Required response: in_ready=0 while out_valid && !out_ready, and the outputs hold.
  - Then all 6 results equal 10, in order, with no loss and no duplicates.
- **Reset mid-flight:**
  - Accept 3 beats, then assert rst for 1 cycle at cycle 2.
  - Required response: out_valid stays 0 until a new beat is accepted, and outputs read 0 after reset.
  - The first post-reset beat (a=5, b=3) emerges 4 cycles later with diff=2.
